uart_mon: RTL and testbench
===========================

UART_MON -- requirements
Module: uart_mon

Interface
REQ-001 The block SHALL accept parameter NUM_CH, default 2, meaning the number of independent UART RX channels (1..16).
REQ-002 The block SHALL accept parameter CLKS_PER_BIT, default 140, meaning clock cycles per UART bit (>=4).
REQ-003 The block SHALL accept parameter FIFO_DEPTH, default 8, meaning output FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have port wb_clk, input, 1 bit: the only clock.
REQ-005 The block SHALL have port wb_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_rx, input, NUM_CH bits: asynchronous serial lines, idle high.
REQ-007 The block SHALL have port o_valid, output, 1 bit: FIFO head is valid.
REQ-008 The block SHALL have port i_ready, input, 1 bit: consumer accepts the head.
REQ-009 The block SHALL have port o_data, output, 8 bits: received byte.
REQ-010 The block SHALL have port o_ch, output, clog2(NUM_CH) bits (min 1): source channel.
REQ-011 The block SHALL have port o_ferr, output, 1 bit: stop bit was sampled low for this byte.
REQ-012 The block SHALL have port o_ovf, output, NUM_CH bits: sticky per-channel overflow flags.
REQ-013 The block SHALL have port i_ovf_clr, input, 1 bit: clears all o_ovf bits.

Function
REQ-014 Each i_rx bit SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-015 Each channel SHALL run its own FSM with states IDLE, START, DATA, STOP.
REQ-016 IDLE->START SHALL occur on a synchronized 1->0 transition; the bit counter SHALL load CLKS_PER_BIT/2-1.
REQ-017 In START, the line SHALL be sampled at counter 0; low -> DATA, high -> IDLE (glitch reject, nothing emitted).
REQ-018 DATA SHALL sample 8 bits, LSB first, one every CLKS_PER_BIT cycles, then go to STOP.
REQ-019 STOP SHALL sample one bit after CLKS_PER_BIT cycles and return to IDLE; a low sample SHALL set ferr for that byte, and the byte SHALL still be emitted.
REQ-020 After STOP, a new start SHALL require a fresh 1->0 edge; a held-low line SHALL NOT retrigger.
REQ-021 Each channel SHALL own a holding register {data, ferr} with a pending flag, set the cycle after the stop sample.
REQ-022 If a byte completes while its channel's pending is still set, the new byte SHALL be dropped, the old byte SHALL be kept, and o_ovf[ch] SHALL be set.
REQ-023 A round-robin arbiter SHALL move at most one pending entry per cycle into the FIFO; the search SHALL start at the channel after the last granted one.
REQ-024 No entry SHALL be written while the FIFO is full, except when a pop occurs in the same cycle.
REQ-025 The FIFO SHALL be first-word fall-through: o_valid = not empty, and o_data/o_ch/o_ferr SHALL show the head.
REQ-026 A pop SHALL occur iff o_valid && i_ready.
REQ-027 Head outputs SHALL be stable while o_valid && !i_ready.
REQ-028 Latency for an uncontended channel with an empty FIFO SHALL be: stop-sample cycle +1 (pending) +1 (FIFO write) -> o_valid asserted.
REQ-029 If i_ovf_clr and a new overflow coincide, the flag SHALL end set.
REQ-030 FIFO pointers SHALL be clog2(FIFO_DEPTH)+1 bits wide, with natural wrap-around; full/empty SHALL be decided by the MSB compare.

Reset
REQ-031 On wb_rst_n low, all FSMs SHALL go to IDLE, all counters and pointers SHALL go to 0, pending and o_ovf SHALL go to 0, synchronizers SHALL go to 1, and the arbiter pointer SHALL go to 0.
REQ-032 During reset, o_valid SHALL be 0, and o_data, o_ch and o_ferr SHALL be 0.
REQ-033 A reset asserted mid-frame SHALL discard the partial byte, and any FIFO contents SHALL be lost.
REQ-034 Deassertion SHALL be synchronized externally; the block SHALL make no timing assumption about it.

Structure
REQ-035 A shared package uart_mon_pkg SHALL hold the RX FSM state enum, the entry record {data[7:0], ch, ferr}, and the clog2 width helper.
REQ-036 The per-channel receiver SHALL be sub-module uart_mon_rx, instantiated NUM_CH times; the arbiter and FIFO SHALL stay in uart_mon.

Verification (bench: CLKS_PER_BIT=16, NUM_CH=2, FIFO_DEPTH=4)
REQ-037 Ch0 sends 0xA5 with a valid stop bit and i_ready=1 -> exactly one o_valid beat with o_data=0xA5, o_ch=0, o_ferr=0, within stop-sample+2 cycles.
REQ-038 Ch1 low pulse of 4 cycles -> no output and FSM back in IDLE; a subsequent 0x3C on ch1 -> o_data=0x3C, o_ch=1.
REQ-039 Both channels finish 0x11 and 0x22 in the same cycle -> two beats on consecutive cycles, in round-robin order; a repeat yields the opposite order.
REQ-040 i_ready=0 while ch0 sends 6 bytes -> FIFO holds 4, pending holds the 5th, the 6th sets o_ovf[0]=1; then i_ready=1 drains exactly 5 bytes in order.
REQ-041 Ch0 sends 0x55 with the stop bit held low -> o_data=0x55, o_ferr=1, and no retrigger until the line returns high and falls again.
REQ-042 wb_rst_n pulsed low mid-DATA on ch0 -> o_valid=0 and o_ovf=0; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types for the multi-channel UART receive monitor: receiver FSM states,
// the FIFO entry record and a channel-index width helper.
package uart_mon_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Wide enough for the largest supported channel count (16).
  localparam int CH_FIELD_W = 4;

  typedef struct packed {
    logic [7:0]            data;
    logic [CH_FIELD_W-1:0] ch;
    logic                  ferr;
  } entry_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_mon_rx.sv
// One UART receive channel: input synchronizer, falling-edge start detect and
// a mid-bit sampling FSM that pulses done on the stop-bit sample.
module uart_mon_rx
  import uart_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 140
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       done,
  output logic [7:0] data,
  output logic       ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state_q, state_d;
  logic             sync_p0, sync_p1, line_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             fall, tick;

  // Synchronizer stage; line_prev lets a start only follow a seen high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_p0   <= rx;
      sync_p1   <= sync_p0;
      line_prev <= sync_p1;
    end
  end

  assign fall = line_prev & ~sync_p1;
  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (tick) state_d = sync_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == RX_STOP) && tick;
    ferr = done && !sync_p1;
    data = shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      case (state_q)
        RX_IDLE: if (fall) cnt <= CNT_HALF;
        RX_START: begin
          if (tick) begin
            cnt     <= CNT_FULL;
            bit_idx <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            cnt     <= CNT_FULL;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: if (!tick) cnt <= cnt - 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (state_q == RX_DATA && tick) shreg <= {sync_p1, shreg[7:1]};
  end

endmodule

// File: rtl/uart_mon.sv
// Multi-channel UART monitor: per-channel receivers feed single-entry holding
// registers, a round-robin arbiter moves them into a first-word fall-through FIFO.
module uart_mon
  import uart_mon_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CLKS_PER_BIT = 140,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            wb_clk,
  input  logic                            wb_rst_n,
  input  logic [NUM_CH-1:0]               i_rx,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [7:0]                      o_data,
  output logic [clog2_min1(NUM_CH)-1:0]   o_ch,
  output logic                            o_ferr,
  output logic [NUM_CH-1:0]               o_ovf,
  input  logic                            i_ovf_clr
);

  localparam int CH_W = clog2_min1(NUM_CH);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;

  logic [NUM_CH-1:0] rx_done, rx_ferr;
  logic [7:0]        rx_data [NUM_CH];
  logic [NUM_CH-1:0] pend, hold_ferr, grant, ovf_set;
  logic [7:0]        hold_data [NUM_CH];
  logic [CH_W-1:0]   rr_ptr, gnt_idx;
  logic              gnt_vld;
  entry_t            mem [FIFO_DEPTH];
  entry_t            wr_entry, head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              empty, full, push, pop;
  logic              unused_ch;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    uart_mon_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
      .clk  (wb_clk),
      .rst_n(wb_rst_n),
      .rx   (i_rx[c]),
      .done (rx_done[c]),
      .data (rx_data[c]),
      .ferr (rx_ferr[c])
    );
  end

  // A byte completing in the same cycle its slot is granted away is accepted,
  // since the slot is free from the next cycle on.
  assign ovf_set = rx_done & pend & ~grant;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pend  <= '0;
      o_ovf <= '0;
    end else begin
      pend  <= (pend & ~grant) | (rx_done & ~ovf_set);
      o_ovf <= (i_ovf_clr ? '0 : o_ovf) | ovf_set;
    end
  end

  always_ff @(posedge wb_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rx_done[c] && !ovf_set[c]) begin
        hold_data[c] <= rx_data[c];
        hold_ferr[c] <= rx_ferr[c];
      end
    end
  end

  // Search begins at the channel after the last one granted.
  always_comb begin
    logic [CH_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
      if (!gnt_vld && pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign push = gnt_vld && (!full || pop);

  always_comb begin
    grant = '0;
    if (push) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    wr_entry.data = hold_data[gnt_idx];
    wr_entry.ch   = CH_FIELD_W'(gnt_idx);
    wr_entry.ferr = hold_ferr[gnt_idx];
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        rr_ptr <= gnt_idx;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = o_valid && i_ready;

  // Head fields are forced to zero whenever the FIFO is empty, including reset.
  assign head      = mem[rd_ptr[AW-1:0]];
  assign o_valid   = !empty;
  assign o_data    = empty ? '0 : head.data;
  assign o_ch      = empty ? '0 : head.ch[CH_W-1:0];
  assign o_ferr    = !empty && head.ferr;
  assign unused_ch = ^head.ch;

endmodule

// File: tb/tb_uart_mon.sv
// Scoreboard bench for uart_mon: directed frames push expected entries, a
// negedge monitor pops and compares on every accepted output beat.
module tb_uart_mon;
  import uart_mon_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CPB    = 16;
  localparam int FD     = 4;

  logic        wb_clk    = 1'b0;
  logic        wb_rst_n  = 1'b0;
  logic [1:0]  i_rx      = 2'b11;
  logic        i_ready   = 1'b0;
  logic        i_ovf_clr = 1'b0;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [0:0]  o_ch;
  logic        o_ferr;
  logic [1:0]  o_ovf;

  uart_mon #(
    .NUM_CH      (NUM_CH),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_rx     (i_rx),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_ch     (o_ch),
    .o_ferr   (o_ferr),
    .o_ovf    (o_ovf),
    .i_ovf_clr(i_ovf_clr)
  );

  always #5 wb_clk = ~wb_clk;

  int cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic [0:0] ch;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   beat_cyc[$];
  int   errors = 0;
  int   checks = 0;
  bit   valid_seen = 1'b0;
  int   valid_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic [0:0] ch, input logic ferr);
    exp_t e;
    e.d = d; e.ch = ch; e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  // Drives start, 8 data bits LSB first and the stop level on enabled channels.
  task automatic send(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1,
                      input logic stop);
    logic [9:0] f0, f1;
    f0 = {stop, d0, 1'b0};
    f1 = {stop, d1, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (en[0]) i_rx[0] = f0[b];
      if (en[1]) i_rx[1] = f1[b];
      step(CPB);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    step(4);
    check(name, exp_q.size(), 0);
  endtask

  exp_t       mon_e;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_d;
  logic [0:0] prev_ch;
  logic       prev_f;

  always @(negedge wb_clk) begin
    if (wb_rst_n && o_valid && !valid_seen) begin
      valid_seen = 1'b1;
      valid_cyc  = cyc;
    end
    if (wb_rst_n && hold_prev && o_valid) begin
      checks++;
      if ({o_data, o_ch, o_ferr} !== {prev_d, prev_ch, prev_f}) begin
        errors++;
        $display("FAIL head_stable: got data=%h ch=%0d ferr=%0b, want data=%h ch=%0d ferr=%0b",
                 o_data, o_ch, o_ferr, prev_d, prev_ch, prev_f);
      end
    end
    if (wb_rst_n && o_valid && i_ready) begin
      beat_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h ch=%0d ferr=%0b, want no beat",
                 o_data, o_ch, o_ferr);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_data !== mon_e.d || o_ch !== mon_e.ch || o_ferr !== mon_e.ferr) begin
          errors++;
          $display("FAIL beat: got data=%h ch=%0d ferr=%0b, want data=%h ch=%0d ferr=%0b",
                   o_data, o_ch, o_ferr, mon_e.d, mon_e.ch, mon_e.ferr);
        end
      end
    end
    hold_prev = wb_rst_n && o_valid && !i_ready;
    prev_d    = o_data;
    prev_ch   = o_ch;
    prev_f    = o_ferr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int t0;
    step(3);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_ch", o_ch, 0);
    check("rst_ferr", o_ferr, 0);
    check("rst_ovf", o_ovf, 0);
    wb_rst_n = 1'b1;
    step(5);
    i_ready = 1'b1;

    // Single byte, uncontended, with latency window.
    expect_beat(8'hA5, 1'b0, 1'b0);
    valid_seen = 1'b0;
    t0 = cyc;
    send(2'b01, 8'hA5, 8'h00, 1'b1);
    step(4);
    checks++;
    if (!(valid_seen && valid_cyc >= t0 + 145 && valid_cyc <= t0 + 156)) begin
      errors++;
      $display("FAIL a5_latency: got valid at start+%0d (seen=%0b), want start+145..156",
               valid_cyc - t0, valid_seen);
    end
    wait_drain("a5_drain", 40);

    // Short glitch on ch1 is rejected, then a real frame.
    i_rx[1] = 1'b0;
    step(4);
    i_rx[1] = 1'b1;
    step(30);
    check("glitch_idle", dut.g_ch[1].u_rx.state_q, RX_IDLE);
    check("glitch_no_valid", o_valid, 0);
    expect_beat(8'h3C, 1'b1, 1'b0);
    send(2'b10, 8'h00, 8'h3C, 1'b1);
    wait_drain("3c_drain", 40);

    // Simultaneous completion: last grant was ch1, so ch0 goes first.
    expect_beat(8'h11, 1'b0, 1'b0);
    expect_beat(8'h22, 1'b1, 1'b0);
    beat_cyc.delete();
    send(2'b11, 8'h11, 8'h22, 1'b1);
    wait_drain("pair1_drain", 40);
    check("pair1_consecutive", beat_cyc.size() == 2 && beat_cyc[1] == beat_cyc[0] + 1, 1);

    // A lone ch0 grant moves the pointer, so the repeat starts at ch1.
    expect_beat(8'h77, 1'b0, 1'b0);
    send(2'b01, 8'h77, 8'h00, 1'b1);
    wait_drain("77_drain", 40);
    expect_beat(8'h22, 1'b1, 1'b0);
    expect_beat(8'h11, 1'b0, 1'b0);
    beat_cyc.delete();
    send(2'b11, 8'h11, 8'h22, 1'b1);
    wait_drain("pair2_drain", 40);
    check("pair2_consecutive", beat_cyc.size() == 2 && beat_cyc[1] == beat_cyc[0] + 1, 1);

    // Back-pressure: 4 in FIFO, 1 pending, 6th overflows.
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_beat(8'(8'h01 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send(2'b01, 8'(8'h01 + i), 8'h00, 1'b1);
    step(4);
    check("full_head", o_data, 8'h01);
    check("full_pending", dut.pend, 2'b01);
    check("ovf_set", o_ovf, 2'b01);
    i_ready = 1'b1;
    wait_drain("drain5", 30);
    check("drain5_empty", o_valid, 0);
    check("ovf_kept", o_ovf, 2'b01);
    i_ovf_clr = 1'b1;
    step(1);
    i_ovf_clr = 1'b0;
    check("ovf_clr", o_ovf, 0);

    // Framing error with the line held low afterwards.
    expect_beat(8'h55, 1'b0, 1'b1);
    send(2'b01, 8'h55, 8'h00, 1'b0);
    step(40);
    check("ferr_no_retrigger", dut.g_ch[0].u_rx.state_q, RX_IDLE);
    wait_drain("ferr_drain", 10);
    step(200);
    check("ferr_still_idle", dut.g_ch[0].u_rx.state_q, RX_IDLE);
    i_rx[0] = 1'b1;
    step(20);
    expect_beat(8'h0F, 1'b0, 1'b0);
    send(2'b01, 8'h0F, 8'h00, 1'b1);
    wait_drain("0f_drain", 40);

    // Reset mid-frame with a byte sitting in the FIFO.
    i_ready = 1'b0;
    send(2'b10, 8'h00, 8'h99, 1'b1);
    step(4);
    check("pre_reset_valid", o_valid, 1);
    i_rx[0] = 1'b0;
    step(4 * CPB);
    check("mid_data", dut.g_ch[0].u_rx.state_q, RX_DATA);
    wb_rst_n = 1'b0;
    i_rx[0]  = 1'b1;
    step(2);
    check("inrst_valid", o_valid, 0);
    check("inrst_data", o_data, 0);
    check("inrst_ovf", o_ovf, 0);
    wb_rst_n = 1'b1;
    step(5);
    check("postrst_valid", o_valid, 0);
    i_ready = 1'b1;
    expect_beat(8'h81, 1'b0, 1'b0);
    send(2'b01, 8'h81, 8'h00, 1'b1);
    wait_drain("81_drain", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
